udm_uart_rx: RTL

- Byte-level UART receiver, 8N1, LSB first. Sits between the SoC serial input pin and the UDM debug-bridge command decoder.
- Synchronises the asynchronous rx line, detects and validates start bits, and samples each bit at its centre.
- Delivers received bytes over a valid/ready stream and flags framing and overrun errors.
- Bit timing is set at run time, so the debug link can switch between 115200 and lower rates without rebuilding.

---
 rtl/udm_uart_rx.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/udm_uart_rx.sv
// rtl/udm_uart_rx.sv - 8N1 UART byte receiver with centre sampling and valid/ready output
// Optional even-parity check (PARITY state, parity_err_o) when UDM_UART_RX_PARITY_EN is defined.
module udm_uart_rx #(
  parameter int DIV_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             rx_i,
  input  logic [DIV_W-1:0] divider_i,
  output logic [7:0]       data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o,
  output logic             frame_err_o,
  output logic             overrun_o
`ifdef UDM_UART_RX_PARITY_EN
  ,
  output logic             parity_err_o
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UDM_UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             cnt_zero;
  logic             done;
  logic             ferr_d;

  logic [7:0] data_q;
  logic       valid_q;
  logic       ferr_q;
  logic       ovr_q;

`ifdef UDM_UART_RX_PARITY_EN
  logic par_ok_q, par_ok_d;
  logic perr_d;
  logic perr_q;
`endif

  // Idle-high line: synchroniser resets to 1 so reset never looks like a start bit.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
    end
  end

  assign rx_s     = sync_q[SYNC_STAGES-1];
  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    done      = 1'b0;
    ferr_d    = 1'b0;
`ifdef UDM_UART_RX_PARITY_EN
    par_ok_d  = par_ok_q;
    perr_d    = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          // Divider is frozen for the whole frame; first wait lands mid start bit.
          div_d   = divider_i;
          cnt_d   = (divider_i >> 1) - DIV_W'(1);
          state_d = START;
        end
      end

      START: begin
        if (cnt_zero) begin
          if (!rx_s) begin
            cnt_d     = div_q - DIV_W'(1);
            bit_idx_d = 3'd0;
            state_d   = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end

      DATA: begin
        if (cnt_zero) begin
          shift_d   = {rx_s, shift_q[7:1]};
          cnt_d     = div_q - DIV_W'(1);
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UDM_UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end

`ifdef UDM_UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_zero) begin
          perr_d   = ^{shift_q, rx_s};
          par_ok_d = ~perr_d;
          cnt_d    = div_q - DIV_W'(1);
          state_d  = STOP;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
`endif

      STOP: begin
        if (cnt_zero) begin
          if (rx_s) begin
`ifdef UDM_UART_RX_PARITY_EN
            done = par_ok_q;
`else
            done = 1'b1;
`endif
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end

      WAIT_IDLE: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      div_q     <= '0;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      ferr_q    <= 1'b0;
`ifdef UDM_UART_RX_PARITY_EN
      par_ok_q  <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      ferr_q    <= ferr_d;
`ifdef UDM_UART_RX_PARITY_EN
      par_ok_q  <= par_ok_d;
      perr_q    <= perr_d;
`endif
    end
  end

  // A completion coinciding with a handshake replaces the byte instead of overrunning.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (done) begin
        if (valid_q && !ready_i) begin
          ovr_q <= 1'b1;
        end else begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end
      end else if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign busy_o      = (state_q != IDLE);
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;
`ifdef UDM_UART_RX_PARITY_EN
  assign parity_err_o = perr_q;
`endif

endmodule
